// File: rtl/i2c_phase_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared constants and FSM encoding for the I2C phase timer
//                and the I2C master that it sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Smallest usable phase length; a requested length of zero is promoted to this.
  localparam int MIN_TICKS = 1;

  // Default geometry used by the I2C master.
  localparam int DEFAULT_SIZE   = 8;
  localparam int DEFAULT_NPHASE = 4;

  // Hold is a qualifier of RUN rather than a separate state.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_phase_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_phase_timer_if
//  Description : Control/status bundle between the I2C master sequencer and
//                the phase timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_phase_timer_if
  import i2c_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int NPHASE = DEFAULT_NPHASE,
  parameter int PW     = $clog2(NPHASE)
) ();

  logic            Start;
  logic            Stop;
  logic            Periodic;
  logic [SIZE-1:0] Ticks;
  logic            Busy;
  logic [PW-1:0]   Phase;
  logic            Tick;
  logic            BitDone;

  // Sequencer side: issues commands, observes timing.
  modport master (
    output Start, Stop, Periodic, Ticks,
    input  Busy, Phase, Tick, BitDone
  );

  // Timer side.
  modport slave (
    input  Start, Stop, Periodic, Ticks,
    output Busy, Phase, Tick, BitDone
  );

endinterface
`default_nettype wire

// File: rtl/i2c_phase_timer_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_tick_counter
//  Description : Loadable down-counter. Reloads when it reaches one instead of
//                wrapping, and flags that terminal count combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_tick_counter #(
  parameter int SIZE = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_load,
  input  wire logic [SIZE-1:0] i_load_val,
  input  wire logic            i_en,
  input  wire logic [SIZE-1:0] i_reload_val,
  output logic                 o_tc
);

  localparam logic [SIZE-1:0] c_one = SIZE'(1);

  logic [SIZE-1:0] r_cnt;
  logic            w_tc;

  assign w_tc = (r_cnt == c_one);
  assign o_tc = w_tc;

  // Load wins over counting; terminal count reloads so the value never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= w_tc ? i_reload_val : (r_cnt - c_one);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_phase_timer
//  Description : Splits each I2C bit into NPHASE equal phases of Ticks enabled
//                cycles; pulses Tick at every phase end and BitDone after the
//                last phase. Supports hold, one-shot/periodic and restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_phase_timer
  import i2c_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int NPHASE = DEFAULT_NPHASE
) (
  input  wire logic        Clk,
  input  wire logic        Rst,
  i2c_phase_timer_if.slave bus
);

  localparam int              PW           = $clog2(NPHASE);
  localparam logic [PW-1:0]   c_last_phase = PW'(NPHASE - 1);
  localparam logic [PW-1:0]   c_phase_one  = PW'(1);
  localparam logic [SIZE-1:0] c_min_ticks  = SIZE'(MIN_TICKS);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SIZE-1:0] r_ticks;
  logic [SIZE-1:0] w_ticks_nxt;
  logic [PW-1:0]   r_phase;
  logic [PW-1:0]   w_phase_nxt;
  logic            r_busy;
  logic            r_tick;
  logic            r_done;
  logic            w_tick_nxt;
  logic            w_done_nxt;
  logic            w_cnt_load;
  logic            w_cnt_en;
  logic            w_cnt_tc;

  // The counter is loaded with the freshly latched length on Start and
  // reloads from the held length at every phase end.
  i2c_tick_counter #(
    .SIZE (SIZE)
  ) u_cnt (
    .clk          (Clk),
    .rst          (Rst),
    .i_load       (w_cnt_load),
    .i_load_val   (w_ticks_nxt),
    .i_en         (w_cnt_en),
    .i_reload_val (r_ticks),
    .o_tc         (w_cnt_tc)
  );

  // Next-state and pulse decode: Start beats hold, expiry and Periodic.
  always_comb begin
    w_state_nxt = r_state;
    w_ticks_nxt = r_ticks;
    w_phase_nxt = r_phase;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    if (bus.Start) begin
      w_ticks_nxt = (bus.Ticks == '0) ? c_min_ticks : bus.Ticks;
      w_cnt_load  = 1'b1;
      w_phase_nxt = '0;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!bus.Stop) begin
            w_cnt_en = 1'b1;
            if (w_cnt_tc) begin
              w_tick_nxt = 1'b1;
              if (r_phase == c_last_phase) begin
                w_done_nxt  = 1'b1;
                w_phase_nxt = '0;
                if (!bus.Periodic) begin
                  w_state_nxt = ST_IDLE;
                end
              end else begin
                w_phase_nxt = r_phase + c_phase_one;
              end
            end
          end
        end
        default: begin
          // IDLE: everything holds until the next Start.
        end
      endcase
    end
  end

  // State and output registers; every output leaves the block from a flop.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_ticks <= '0;
      r_phase <= '0;
      r_busy  <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ticks <= w_ticks_nxt;
      r_phase <= w_phase_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.Busy    = r_busy;
  assign bus.Phase   = r_phase;
  assign bus.Tick    = r_tick;
  assign bus.BitDone = r_done;

endmodule
`default_nettype wire
